// File: rtl/stream_pkg.sv
// Shared definitions for the 128-bit stream packer: word geometry, length-width
// helper and the packer state encoding.
package stream_pkg;

    localparam int unsigned WORD_W = 128;
    localparam int unsigned FILL_W = 7;
    localparam int unsigned SUM_W  = 8;

    // Width of a field-length value able to hold 0..dw.
    function automatic int unsigned len_w(input int unsigned dw);
        return $clog2(dw + 1);
    endfunction

    typedef logic [0:0] state_t;
    localparam state_t FILL  = 1'b0;
    localparam state_t FLUSH = 1'b1;

endpackage

// File: rtl/stream_pack_merge.sv
// Combinational merge: masks a field to its length and ORs it above the
// bits already held in the accumulator.
module stream_pack_merge
    import stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 22,
    parameter int unsigned LEN_W      = len_w(DATA_WIDTH)
) (
    input  logic [WORD_W-1:0]            acc,
    input  logic [FILL_W-1:0]            fill,
    input  logic [DATA_WIDTH-1:0]        field_data,
    input  logic [LEN_W-1:0]             field_len,
    output logic [WORD_W+DATA_WIDTH-1:0] comb,
    output logic [SUM_W-1:0]             sum
);

    localparam int unsigned COMB_W = WORD_W + DATA_WIDTH;

    logic [DATA_WIDTH-1:0] masked;

    // Clear every bit at or above field_len.
    always_comb begin
        masked = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            masked[i] = field_data[i] & (i < 32'(field_len));
        end
    end

    assign comb = COMB_W'(acc) | (COMB_W'(masked) << fill);
    assign sum  = SUM_W'(fill) + SUM_W'(field_len);

endmodule

// File: rtl/stream_pack.sv
// Transmit-side bit packer: concatenates variable-length fields LSB-first into
// 128-bit framed words under a ready/valid handshake on both sides.
module stream_pack
    import stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 22,
    parameter int unsigned LEN_W      = len_w(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  field_valid,
    input  logic                  field_sop,
    input  logic                  field_eop,
    input  logic [LEN_W-1:0]      field_len,
    input  logic [DATA_WIDTH-1:0] field_data,
    output logic                  field_ready,
    output logic                  valid_out,
    output logic                  sop_out,
    output logic                  eop_out,
    output logic [WORD_W-1:0]     data_out,
    input  logic                  ready_in,
    output logic                  err_out
);

    localparam int unsigned COMB_W = WORD_W + DATA_WIDTH;

    state_t              state,       state_nxt;
    logic [WORD_W-1:0]   acc,         acc_nxt;
    logic [FILL_W-1:0]   fill,        fill_nxt;
    logic                sop_pending, sop_pending_nxt;
    logic                valid_nxt;
    logic                sop_nxt;
    logic                eop_nxt;
    logic                err_nxt;
    logic [WORD_W-1:0]   data_nxt;

    logic                out_free;
    logic                accept;
    logic                sop_eff;
    logic [WORD_W-1:0]   merge_acc;
    logic [FILL_W-1:0]   merge_fill;
    logic [COMB_W-1:0]   comb;
    logic [SUM_W-1:0]    sum;
    logic [WORD_W-1:0]   remainder;

    assign out_free    = !valid_out || ready_in;
    assign field_ready = (state == FILL) && out_free;
    assign accept      = field_valid && field_ready;
    assign sop_eff     = sop_pending || field_sop;

    // A sop restarts the packet, so any partially packed bits are dropped.
    assign merge_acc  = field_sop ? '0 : acc;
    assign merge_fill = field_sop ? '0 : fill;

    stream_pack_merge #(
        .DATA_WIDTH (DATA_WIDTH),
        .LEN_W      (LEN_W)
    ) u_merge (
        .acc        (merge_acc),
        .fill       (merge_fill),
        .field_data (field_data),
        .field_len  (field_len),
        .comb       (comb),
        .sum        (sum)
    );

    assign remainder = WORD_W'(comb[COMB_W-1:WORD_W]);

    // Next-state, accumulator and output-word decode.
    always_comb begin
        state_nxt       = state;
        acc_nxt         = acc;
        fill_nxt        = fill;
        sop_pending_nxt = sop_pending;
        valid_nxt       = valid_out && !ready_in;
        sop_nxt         = sop_out;
        eop_nxt         = eop_out;
        data_nxt        = data_out;
        err_nxt         = 1'b0;

        case (state)
            FILL: begin
                if (accept) begin
                    if (field_sop && (fill != '0)) begin
                        err_nxt = 1'b1;
                    end
                    sop_pending_nxt = sop_eff;
                    if (!field_eop && (sum < SUM_W'(WORD_W))) begin
                        acc_nxt  = comb[WORD_W-1:0];
                        fill_nxt = FILL_W'(sum);
                    end else if (!field_eop) begin
                        valid_nxt       = 1'b1;
                        data_nxt        = comb[WORD_W-1:0];
                        sop_nxt         = sop_eff;
                        eop_nxt         = 1'b0;
                        sop_pending_nxt = 1'b0;
                        acc_nxt         = remainder;
                        fill_nxt        = FILL_W'(sum - SUM_W'(WORD_W));
                    end else if (sum <= SUM_W'(WORD_W)) begin
                        valid_nxt       = 1'b1;
                        data_nxt        = comb[WORD_W-1:0];
                        sop_nxt         = sop_eff;
                        eop_nxt         = 1'b1;
                        sop_pending_nxt = 1'b0;
                        acc_nxt         = '0;
                        fill_nxt        = '0;
                    end else begin
                        // Packet tail spills past this word; finish it from FLUSH.
                        valid_nxt       = 1'b1;
                        data_nxt        = comb[WORD_W-1:0];
                        sop_nxt         = sop_eff;
                        eop_nxt         = 1'b0;
                        sop_pending_nxt = 1'b0;
                        acc_nxt         = remainder;
                        fill_nxt        = FILL_W'(sum - SUM_W'(WORD_W));
                        state_nxt       = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (out_free) begin
                    valid_nxt = 1'b1;
                    data_nxt  = acc;
                    sop_nxt   = 1'b0;
                    eop_nxt   = 1'b1;
                    acc_nxt   = '0;
                    fill_nxt  = '0;
                    state_nxt = FILL;
                end
            end
            default: begin
                state_nxt = FILL;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= FILL;
            acc         <= '0;
            fill        <= '0;
            sop_pending <= 1'b0;
            valid_out   <= 1'b0;
            sop_out     <= 1'b0;
            eop_out     <= 1'b0;
            data_out    <= '0;
            err_out     <= 1'b0;
        end else begin
            state       <= state_nxt;
            acc         <= acc_nxt;
            fill        <= fill_nxt;
            sop_pending <= sop_pending_nxt;
            valid_out   <= valid_nxt;
            sop_out     <= sop_nxt;
            eop_out     <= eop_nxt;
            data_out    <= data_nxt;
            err_out     <= err_nxt;
        end
    end

    len_legal: assert property (@(posedge clk) disable iff (!rst_n)
        (field_valid && field_ready) |-> (32'(field_len) <= DATA_WIDTH));

endmodule

// File: tb/tb_stream_pack.sv
// Bench for stream_pack: directed vector table, hand-written corner sequences and
// randomized traffic checked against a bit-queue packet model.
module tb_stream_pack;

    localparam int unsigned DW = 22;
    localparam int unsigned LW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          field_valid = 1'b0;
    logic          field_sop = 1'b0;
    logic          field_eop = 1'b0;
    logic [LW-1:0] field_len = '0;
    logic [DW-1:0] field_data = '0;
    logic          field_ready;
    logic          valid_out;
    logic          sop_out;
    logic          eop_out;
    logic [127:0]  data_out;
    logic          ready_in;
    logic          err_out;

    bit rand_ready  = 1'b0;
    bit ready_force = 1'b1;
    bit rand_bit    = 1'b1;
    assign ready_in = rand_ready ? rand_bit : ready_force;

    int checks = 0;
    int errors = 0;

    stream_pack #(.DATA_WIDTH(DW), .LEN_W(LW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .field_valid (field_valid),
        .field_sop   (field_sop),
        .field_eop   (field_eop),
        .field_len   (field_len),
        .field_data  (field_data),
        .field_ready (field_ready),
        .valid_out   (valid_out),
        .sop_out     (sop_out),
        .eop_out     (eop_out),
        .data_out    (data_out),
        .ready_in    (ready_in),
        .err_out     (err_out)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #1;
        rand_bit = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    // Reference model: the packet is a queue of bits, cut into 128-bit words.
    typedef struct {
        logic [127:0] d;
        bit           s;
        bit           e;
    } word_t;

    bit    mq[$];
    word_t expq[$];
    bit    pend = 1'b0;
    bit    exp_err = 1'b0;

    task automatic model_accept(input bit s, input bit e, input int len, input logic [DW-1:0] d);
        word_t w;
        if (s) begin
            if (mq.size() != 0) exp_err = 1'b1;
            mq.delete();
            pend = 1'b1;
        end
        for (int i = 0; i < len; i++) mq.push_back(d[i]);
        while (mq.size() >= 128 && !(e && mq.size() == 128)) begin
            w.d = '0;
            for (int i = 0; i < 128; i++) w.d[i] = mq.pop_front();
            w.s = pend;
            w.e = 1'b0;
            pend = 1'b0;
            expq.push_back(w);
        end
        if (e) begin
            w.d = '0;
            for (int i = 0; mq.size() > 0; i++) w.d[i] = mq.pop_front();
            w.s = pend;
            w.e = 1'b1;
            pend = 1'b0;
            expq.push_back(w);
        end
    endtask

    logic [127:0] p_data;
    bit           p_s, p_e, p_hold = 1'b0;

    // Scoreboard: output transfers, held-word stability, error pulses, accepted fields.
    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            expq.delete();
            pend    = 1'b0;
            exp_err = 1'b0;
            p_hold  = 1'b0;
        end else begin
            word_t w;
            chk("err_pulse", 128'(err_out), 128'(exp_err));
            exp_err = 1'b0;
            if (p_hold) begin
                chk("hold_valid", 128'(valid_out), 128'(1'b1));
                chk("hold_data", data_out, p_data);
                chk("hold_sop", 128'(sop_out), 128'(p_s));
                chk("hold_eop", 128'(eop_out), 128'(p_e));
            end
            p_hold = valid_out && !ready_in;
            p_data = data_out;
            p_s    = sop_out;
            p_e    = eop_out;
            if (valid_out && ready_in) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_word: got data %h, required no word", data_out);
                end else begin
                    w = expq.pop_front();
                    checks--;
                    chk("word_data", data_out, w.d);
                    chk("word_sop", 128'(sop_out), 128'(w.s));
                    chk("word_eop", 128'(eop_out), 128'(w.e));
                end
            end
            if (field_valid && field_ready)
                model_accept(field_sop, field_eop, int'(field_len), field_data);
        end
    end

    task automatic send_field(input bit s, input bit e, input int len, input logic [DW-1:0] d);
        int n;
        field_sop   = s;
        field_eop   = e;
        field_len   = LW'(len);
        field_data  = d;
        field_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!field_ready) begin
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL field_ready_timeout: field_ready stayed 0, required 1");
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        field_valid = 1'b0;
    endtask

    typedef struct {
        bit           s, e;
        int           len;
        logic [DW-1:0] d;
        bit           ev, es, ee, er;
        logic [127:0] ed;
        bit           fl;
        logic [127:0] fd;
    } vec_t;

    function automatic vec_t mk(bit s, bit e, int len, logic [DW-1:0] d, bit ev,
                                logic [127:0] ed, bit es, bit ee, bit er,
                                bit fl, logic [127:0] fd);
        vec_t v;
        v.s = s; v.e = e; v.len = len; v.d = d;
        v.ev = ev; v.ed = ed; v.es = es; v.ee = ee; v.er = er;
        v.fl = fl; v.fd = fd;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         tbl[$];
        logic [127:0] ones;
        logic [127:0] w0;
        int           n;

        ones = '1;
        w0   = {8'hCD, {120{1'b1}}};
        tbl.push_back(mk(1, 1, 10, 22'h3FF,    1, 128'h3FF, 1, 1, 0, 0, '0));
        tbl.push_back(mk(1, 0, 22, 22'h3FFFFF, 0, '0, 0, 0, 0, 0, '0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 0, 22, 22'h3FFFFF, 0, '0, 0, 0, 0, 0, '0));
        tbl.push_back(mk(0, 0, 22, 22'h3FFFFF, 1, ones, 1, 0, 0, 0, '0));
        tbl.push_back(mk(0, 1, 0, 22'h0,       1, 128'hF, 0, 1, 0, 0, '0));
        tbl.push_back(mk(1, 0, 22, 22'h3FFFFF, 0, '0, 0, 0, 0, 0, '0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 0, 22, 22'h3FFFFF, 0, '0, 0, 0, 0, 0, '0));
        tbl.push_back(mk(0, 0, 10, 22'h3FF,    0, '0, 0, 0, 0, 0, '0));
        tbl.push_back(mk(0, 1, 16, 22'hABCD,   1, w0, 1, 0, 0, 1, 128'hAB));
        tbl.push_back(mk(1, 1, 4, 22'h3FFFFF,  1, 128'hF, 1, 1, 0, 0, '0));
        tbl.push_back(mk(1, 0, 22, 22'h3FFFFF, 0, '0, 0, 0, 0, 0, '0));
        tbl.push_back(mk(0, 0, 22, 22'h3FFFFF, 0, '0, 0, 0, 0, 0, '0));
        tbl.push_back(mk(0, 0, 6, 22'h3F,      0, '0, 0, 0, 0, 0, '0));
        tbl.push_back(mk(1, 1, 8, 22'hA5,      1, 128'hA5, 1, 1, 1, 0, '0));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 128'(valid_out), 128'(1'b0));
        chk("rst_data", data_out, '0);
        chk("rst_sop_eop_err", 128'({sop_out, eop_out, err_out}), 128'(3'b000));
        rst_n = 1'b1;
        chk("rst_field_ready", 128'(field_ready), 128'(1'b1));

        foreach (tbl[k]) begin
            send_field(tbl[k].s, tbl[k].e, tbl[k].len, tbl[k].d);
            chk($sformatf("v%0d_valid", k), 128'(valid_out), 128'(tbl[k].ev));
            chk($sformatf("v%0d_err", k), 128'(err_out), 128'(tbl[k].er));
            if (tbl[k].ev) begin
                chk($sformatf("v%0d_data", k), data_out, tbl[k].ed);
                chk($sformatf("v%0d_sop", k), 128'(sop_out), 128'(tbl[k].es));
                chk($sformatf("v%0d_eop", k), 128'(eop_out), 128'(tbl[k].ee));
            end
            if (tbl[k].fl) begin
                chk($sformatf("v%0d_ready_flush", k), 128'(field_ready), 128'(1'b0));
                @(posedge clk);
                #1;
                chk($sformatf("v%0d_flush_valid", k), 128'(valid_out), 128'(1'b1));
                chk($sformatf("v%0d_flush_data", k), data_out, tbl[k].fd);
                chk($sformatf("v%0d_flush_sop_eop", k), 128'({sop_out, eop_out}), 128'(2'b01));
                chk($sformatf("v%0d_ready_after", k), 128'(field_ready), 128'(1'b1));
            end
        end

        // Backpressure: word stays put for 3 stalled cycles, then hands over to the next word.
        @(posedge clk);
        #1;
        ready_force = 1'b0;
        send_field(1, 1, 4, 22'h3FFFFF);
        chk("bp_first", data_out, 128'hF);
        field_sop = 1'b1; field_eop = 1'b1; field_len = LW'(3); field_data = 22'h3FFFF5;
        field_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("bp_valid", 128'(valid_out), 128'(1'b1));
            chk("bp_data", data_out, 128'hF);
            chk("bp_sop_eop", 128'({sop_out, eop_out}), 128'(2'b11));
            chk("bp_ready", 128'(field_ready), 128'(1'b0));
        end
        ready_force = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 128'(field_ready), 128'(1'b1));
        @(posedge clk);
        #1;
        field_valid = 1'b0;
        chk("bp_next_valid", 128'(valid_out), 128'(1'b1));
        chk("bp_next_data", data_out, 128'h5);
        chk("bp_next_sop_eop", 128'({sop_out, eop_out}), 128'(2'b11));

        // Reset mid-packet at fill 30 discards buffered bits.
        send_field(1, 0, 22, 22'h3FFFFF);
        send_field(0, 0, 8, 22'hFF);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("mid_rst_valid", 128'(valid_out), 128'(1'b0));
        chk("mid_rst_data", data_out, '0);
        chk("mid_rst_flags", 128'({sop_out, eop_out, err_out}), 128'(3'b000));
        send_field(0, 1, 0, 22'h0);
        chk("post_rst_valid", 128'(valid_out), 128'(1'b1));
        chk("post_rst_data", data_out, '0);
        chk("post_rst_sop_eop", 128'({sop_out, eop_out}), 128'(2'b01));

        // Randomized traffic against the model.
        rand_ready = 1'b1;
        repeat (400) begin
            send_field($urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
                       int'($urandom_range(0, DW)), DW'($urandom));
        end
        rand_ready  = 1'b0;
        ready_force = 1'b1;
        n = 0;
        while (expq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk("drain_pending_words", 128'(expq.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
